ntt_lane_permute: RTL and testbench
===================================

// Module: ntt_lane_permute
// PURPOSE
//  Registered, parametrised lane-permutation stage between the NTT butterfly array and result writeback.
//  Generalises the fixed 16-lane identity result path with four runtime-selectable permutations:
//  identity, bit-reverse, radix stride and rotate.
//  Adds valid/ready flow control with a skid buffer and frame tracking with a last-beat flag.
// PARAMETERS
//  P_WIDTH      64  bits per lane
//  P_LANES      16  lane count; power of 2, >=2
//  P_RADIX      4   stride-mode radix; divides P_LANES
//  P_FRAME_LEN  16  accepted beats per frame; >=1
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst_n        in   1                  asynchronous, active-low reset
//  flush        in   1                  sync clear: empty buffers, zero beat counter
//  cfg_mode     in   2                  0 identity, 1 bit-reverse, 2 stride, 3 rotate
//  cfg_rot      in   $clog2(P_LANES)    rotate amount (mode 3)
//  in_valid     in   1                  input beat valid
//  in_ready     out  1                  stage can accept a beat
//  in_data      in   P_LANES*P_WIDTH    lane i = bits [i*P_WIDTH +: P_WIDTH]
//  out_valid    out  1                  output beat valid
//  out_ready    in   1                  downstream accepts
//  out_data     out  P_LANES*P_WIDTH    permuted lanes
//  out_last     out  1                  beat is last of its frame
//  frame_active out  1                  beat counter != 0, i.e. mid-frame
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_last=0, in_ready=1, frame_active=0, beat_cnt=0,
//   skid empty, active mode=0, active rot=0. Reset mid-frame discards all held beats.
//  Permutation: out lane p(i) <= in lane i.
//   - mode 0: p(i)=i.
//   - mode 1: p(i)=bitrev(i, log2 P_LANES).
//   - mode 2: p(i)=(i%P_RADIX)*(P_LANES/P_RADIX)+i/P_RADIX.
//   - mode 3: p(i)=(i+rot) mod P_LANES; wraps.
//  Config sampling: cfg_mode/cfg_rot are used directly on the beat accepted at beat_cnt==0 and latched.
//   The latched values are used for beats 1..P_FRAME_LEN-1. Mid-frame config changes are ignored.
//  Accept = in_valid & in_ready. On accept, beat_cnt increments; at P_FRAME_LEN-1 it wraps to 0.
//   That beat carries last=1.
//  Latency: accepted beat appears on out_* the next cycle when the output register is free.
//   Throughput is 1 beat/clk with out_ready held high.
//  Skid: if out_valid & ~out_ready and a beat is accepted, the beat goes to the 1-entry skid.
//   in_ready is registered: in_ready = ~skid_full.
//   When the output register drains, the skid moves into it the same edge it is consumed.
//  out_data/out_last hold stable while out_valid & ~out_ready (no change under backpressure).
//  Order is strictly preserved; no beat is dropped or duplicated except on flush or reset.
//  flush=1: next edge clears out_valid, the skid and beat_cnt, and sets out_data=0.
//   in_ready=0 during the flush cycle. Flush overrides a simultaneous accept; that beat is dropped.
//  Simultaneous drain + accept with the skid empty: the output register reloads from the input.
//   No bubble.
//  P_FRAME_LEN=1: every beat is last and samples config.
// STRUCTURE
//  Shared package ntt_perm_pkg:
//   - mode localparams: MODE_ID, MODE_BITREV, MODE_STRIDE, MODE_ROT.
//   - function bitrev(idx, nbits).
//   - function stride_idx(idx, lanes, radix).
//  Sub-module ntt_skid_buf (P_DW = P_LANES*P_WIDTH+1; data+last): 2-register valid/ready skid.
//  Permutation is a combinational generate network ahead of the skid. Beat counter and config latch are local.
// TESTING
//  Lane i = 64'h1000+i, mode 0, out_ready=1 -> out lane i = 64'h1000+i, 1 clk latency.
//  Mode 1, same data -> out lane 8 = 64'h1001; out lane 15 = 64'h100F.
//  Mode 2, R=4 -> out lane 4 = 64'h1001; out lane 1 = 64'h1004.
//  Mode 3, rot=3 -> out lane 3 = 64'h1000; out lane 0 = 64'h100D (wrap).
//  Mode switched 0->1 at beat 5 -> beats 5..15 stay identity. Beat 16 (next frame) is bit-reversed.
//   out_last=1 on beats 15 and 31.
//  Backpressure and resets:
//   - out_ready low 3 clk with in_valid held -> one beat in skid, in_ready=0, no loss, order kept.
//   - flush at beat 7 -> beat_cnt=0, out_valid=0.
//   - rst_n low mid-frame -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ntt_perm_pkg.sv
// ntt_perm_pkg
//   Shared definitions for the NTT lane-permutation stage.
//   - MODE_* : encodings of the cfg_mode field.
//   - bitrev(idx, nbits)             : reverse the low nbits of idx.
//   - stride_idx(idx, lanes, radix)  : (idx % radix) * (lanes / radix) + idx / radix.
//     stride_idx with radix' = lanes/radix is the inverse of stride_idx with radix,
//     which lets the datapath be written as an output-lane gather.
package ntt_perm_pkg;

  localparam logic [1:0] MODE_ID     = 2'd0;
  localparam logic [1:0] MODE_BITREV = 2'd1;
  localparam logic [1:0] MODE_STRIDE = 2'd2;
  localparam logic [1:0] MODE_ROT    = 2'd3;

  function automatic int bitrev(input int idx, input int nbits);
    int r;
    r = 0;
    for (int b = 0; b < nbits; b++) begin
      r = (r << 1) | ((idx >> b) & 1);
    end
    return r;
  endfunction

  function automatic int stride_idx(input int idx, input int lanes, input int radix);
    return (idx % radix) * (lanes / radix) + idx / radix;
  endfunction

endpackage

// File: rtl/ntt_skid_buf.sv
// ntt_skid_buf
//   Two-register valid/ready stage: an output register plus a one-entry skid.
//   A beat accepted while the output is stalled lands in the skid; when the
//   output drains, the skid moves into the output register on the same edge.
//   in_ready comes straight from the skid-full flop (gated off while flushing),
//   so there is no combinational ready path from out_ready to in_ready.
// Ports
//   clk, rst_n           clock, async active-low reset
//   flush                sync clear of both registers; drops any beat offered
//   in_valid/in_ready    upstream handshake
//   in_data  [P_DW]      upstream payload
//   out_valid/out_ready  downstream handshake
//   out_data [P_DW]      downstream payload, held stable while stalled
module ntt_skid_buf #(
  parameter int P_DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [P_DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [P_DW-1:0] out_data
);

  logic            r_out_valid;
  logic [P_DW-1:0] r_out_data;
  logic            r_skid_full;
  logic [P_DW-1:0] r_skid_data;

  logic            w_accept;
  logic            w_out_free;

  assign in_ready   = ~r_skid_full & ~flush;
  assign w_accept   = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_skid_full <= 1'b0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_skid_full <= 1'b0;
    end else if (w_out_free) begin
      // skid full implies in_ready was low, so no accept can coincide here
      if (r_skid_full) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
        r_skid_full <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_full <= 1'b1;
      r_skid_data <= in_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: rtl/ntt_lane_permute.sv
// ntt_lane_permute
//   Registered lane-permutation stage between the NTT butterfly array and
//   result writeback. Out lane p(i) receives in lane i, where p is one of:
//   identity, bit-reverse, radix stride, rotate-by-cfg_rot.
//   Config is taken live on the first beat of a frame and latched for the rest
//   of the frame. Beat P_FRAME_LEN-1 of each frame carries out_last.
// Ports
//   clk, rst_n               clock, async active-low reset
//   flush                    sync clear of buffers and beat counter
//   cfg_mode [2], cfg_rot    permutation select / rotate amount
//   in_valid/in_ready        upstream handshake
//   in_data  [LANES*WIDTH]   lane i = bits [i*P_WIDTH +: P_WIDTH]
//   out_valid/out_ready      downstream handshake
//   out_data [LANES*WIDTH]   permuted lanes
//   out_last                 last beat of a frame
//   frame_active             beat counter non-zero (mid-frame)
module ntt_lane_permute
  import ntt_perm_pkg::*;
#(
  parameter int P_WIDTH     = 64,
  parameter int P_LANES     = 16,
  parameter int P_RADIX     = 4,
  parameter int P_FRAME_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [1:0]                   cfg_mode,
  input  logic [$clog2(P_LANES)-1:0]   cfg_rot,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [P_LANES*P_WIDTH-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [P_LANES*P_WIDTH-1:0]   out_data,
  output logic                         out_last,
  output logic                         frame_active
);

  localparam int LW   = $clog2(P_LANES);
  localparam int CW   = (P_FRAME_LEN > 1) ? $clog2(P_FRAME_LEN) : 1;
  localparam int DW   = P_LANES * P_WIDTH;
  localparam int P_DW = DW + 1;

  // ---------------------------------------------------------------------------
  // Beat counter and config latch
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_beat_cnt;
  logic [1:0]    r_mode;
  logic [LW-1:0] r_rot;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_frame_start;
  logic          w_last;
  logic [1:0]    w_mode;
  logic [LW-1:0] w_rot;

  assign w_accept      = in_valid & w_in_ready;
  assign w_frame_start = (r_beat_cnt == '0);
  assign w_last        = (r_beat_cnt == CW'(P_FRAME_LEN - 1));

  // first beat of a frame uses the live config; later beats use the latch
  assign w_mode = w_frame_start ? cfg_mode : r_mode;
  assign w_rot  = w_frame_start ? cfg_rot  : r_rot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (flush) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) r_beat_cnt <= '0;
      else        r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_ID;
      r_rot  <= '0;
    end else if (w_accept && w_frame_start) begin
      r_mode <= cfg_mode;
      r_rot  <= cfg_rot;
    end
  end

  assign frame_active = |r_beat_cnt;

  // ---------------------------------------------------------------------------
  // Permutation network, written as a gather per output lane o:
  //   bit-reverse is its own inverse; stride inverts by swapping the radix
  //   for lanes/radix; rotate-left by rot gathers from lane o-rot (mod lanes,
  //   free wrap since lane count is a power of two).
  // ---------------------------------------------------------------------------
  logic [P_WIDTH-1:0] w_in_lane [P_LANES];
  logic [DW-1:0]      w_perm_data;

  for (genvar i = 0; i < P_LANES; i++) begin : g_unpack
    assign w_in_lane[i] = in_data[i*P_WIDTH +: P_WIDTH];
  end

  for (genvar o = 0; o < P_LANES; o++) begin : g_lane
    localparam logic [LW-1:0] SRC_BR = LW'(bitrev(o, LW));
    localparam logic [LW-1:0] SRC_ST = LW'(stride_idx(o, P_LANES, P_LANES / P_RADIX));

    logic [LW-1:0]      w_rot_src;
    logic [P_WIDTH-1:0] w_lane_out;

    assign w_rot_src = LW'(o) - w_rot;

    always_comb begin
      w_lane_out = w_in_lane[o];
      case (w_mode)
        MODE_BITREV: w_lane_out = w_in_lane[SRC_BR];
        MODE_STRIDE: w_lane_out = w_in_lane[SRC_ST];
        MODE_ROT:    w_lane_out = w_in_lane[w_rot_src];
        default:     w_lane_out = w_in_lane[o];
      endcase
    end

    assign w_perm_data[o*P_WIDTH +: P_WIDTH] = w_lane_out;
  end

  // ---------------------------------------------------------------------------
  // Output register + skid; last rides along as the top payload bit
  // ---------------------------------------------------------------------------
  logic [P_DW-1:0] w_skid_in;
  logic [P_DW-1:0] w_skid_out;

  assign w_skid_in = {w_last, w_perm_data};

  ntt_skid_buf #(
    .P_DW (P_DW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_skid_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_skid_out)
  );

  assign in_ready = w_in_ready;
  assign out_data = w_skid_out[DW-1:0];
  assign out_last = w_skid_out[P_DW-1];

endmodule

// File: tb/tb_ntt_lane_permute.sv
module tb_ntt_lane_permute;

  localparam int W  = 64;
  localparam int L  = 16;
  localparam int R  = 4;
  localparam int FL = 16;
  localparam int LOG_L = 4;
  localparam int DWA = L * W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic [1:0]     cfg_mode;
  logic [LOG_L-1:0] cfg_rot;
  logic           in_valid;
  logic           in_ready;
  logic [DWA-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [DWA-1:0] out_data;
  logic           out_last;
  logic           frame_active;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ntt_lane_permute #(
    .P_WIDTH(W), .P_LANES(L), .P_RADIX(R), .P_FRAME_LEN(FL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cfg_mode(cfg_mode), .cfg_rot(cfg_rot),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_active(frame_active)
  );

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [DWA-1:0] act, input logic [DWA-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      for (int i = 0; i < L; i++) begin
        if (act[i*W +: W] !== exp[i*W +: W]) begin
          $display("FAIL %s: lane %0d got %0h expected %0h (t=%0t)",
                   name, i, act[i*W +: W], exp[i*W +: W], $time);
          break;
        end
      end
    end
  endtask

  // Reference permutation: forward mapping out[p(i)] = in[i]
  function automatic logic [DWA-1:0] perm_ref(input logic [DWA-1:0] d, input int mode, input int rot);
    logic [DWA-1:0] r;
    int dest;
    r = '0;
    for (int i = 0; i < L; i++) begin
      case (mode)
        1: begin
          dest = 0;
          for (int b = 0; b < LOG_L; b++)
            if ((i >> b) & 1) dest += L >> (b + 1);
        end
        2: dest = (i % R) * (L / R) + i / R;
        3: dest = (i + rot) % L;
        default: dest = i;
      endcase
      r[dest*W +: W] = d[i*W +: W];
    end
    return r;
  endfunction

  function automatic logic [DWA-1:0] seq_data(input int b);
    logic [DWA-1:0] d;
    for (int i = 0; i < L; i++) d[i*W +: W] = 64'h1000 + 64'(i) + 64'(b) * 64'h100;
    return d;
  endfunction

  function automatic logic [DWA-1:0] rand_data();
    logic [DWA-1:0] d;
    for (int i = 0; i < DWA / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: beats in flight = accepted but not yet taken downstream.
  // The stage holds at most two (output register + skid).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DWA-1:0] data;
    logic           last;
  } beat_t;

  beat_t          exp_q[$];
  int             m_cnt;
  int             m_mode;
  int             m_rot;
  bit             prev_stall;
  logic [DWA-1:0] prev_data;
  logic           prev_last;

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0; m_mode = 0; m_rot = 0;
      prev_stall = 1'b0;
    end else begin
      chk("sb_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("sb_in_ready", 64'(in_ready), 64'(!flush && exp_q.size() < 2));
      chk("sb_frame_active", 64'(frame_active), 64'(m_cnt != 0));
      if (prev_stall) begin
        chk_data("stall_data_hold", out_data, prev_data);
        chk("stall_last_hold", 64'(out_last), 64'(prev_last));
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      prev_last  = out_last;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL sb_unexpected_beat: got beat expected none (t=%0t)", $time);
        end else begin
          b = exp_q.pop_front();
          chk_data("sb_data", out_data, b.data);
          chk("sb_last", 64'(out_last), 64'(b.last));
        end
      end

      if (flush) begin
        exp_q.delete();
        m_cnt = 0;
      end else if (in_valid && in_ready) begin
        if (m_cnt == 0) begin
          m_mode = int'(cfg_mode);
          m_rot  = int'(cfg_rot);
        end
        b.data = perm_ref(in_data, m_mode, m_rot);
        b.last = (m_cnt == FL - 1);
        exp_q.push_back(b);
        m_cnt = (m_cnt + 1) % FL;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    #1;
    chk("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_frame_active", 64'(frame_active), 64'd0);
    chk("flush_out_data", out_data[63:0], 64'd0);
  endtask

  task automatic send_held(input logic [DWA-1:0] d, input int max_cyc);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    acc = 1'b0;
    for (int c = 0; c < max_cyc && !acc; c++) begin
      acc = in_ready;
      step();
    end
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: got no accept expected accept within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      step();
      c++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic [LOG_L-1:0] rot;
    int               lane;
    logic [63:0]      exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'd0, 4'd0, 0,  64'h1000};
    vecs[1]  = '{2'd0, 4'd0, 7,  64'h1007};
    vecs[2]  = '{2'd0, 4'd0, 15, 64'h100F};
    vecs[3]  = '{2'd1, 4'd0, 8,  64'h1001};
    vecs[4]  = '{2'd1, 4'd0, 15, 64'h100F};
    vecs[5]  = '{2'd1, 4'd0, 1,  64'h1008};
    vecs[6]  = '{2'd2, 4'd0, 4,  64'h1001};
    vecs[7]  = '{2'd2, 4'd0, 1,  64'h1004};
    vecs[8]  = '{2'd2, 4'd0, 15, 64'h100F};
    vecs[9]  = '{2'd3, 4'd3, 3,  64'h1000};
    vecs[10] = '{2'd3, 4'd3, 0,  64'h100D};
    vecs[11] = '{2'd3, 4'd3, 2,  64'h100F};

    rst_n = 1'b0; flush = 1'b0; cfg_mode = 2'd0; cfg_rot = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_frame_active", 64'(frame_active), 64'd0);
    chk_data("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    step();

    // single-beat vectors, each at frame start
    foreach (vecs[v]) begin
      flush_pulse();
      in_valid = 1'b1;
      in_data  = seq_data(0);
      cfg_mode = vecs[v].mode;
      cfg_rot  = vecs[v].rot;
      step();
      in_valid = 1'b0;
      chk("vec_latency_valid", 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_lane%0d", v, vecs[v].lane),
          out_data[vecs[v].lane*W +: W], vecs[v].exp);
    end
    step();

    // mode switch mid-frame is ignored until the next frame
    flush_pulse();
    cfg_rot = '0;
    for (int b = 0; b < 32; b++) begin
      in_valid = 1'b1;
      in_data  = seq_data(b);
      cfg_mode = (b < 5) ? 2'd0 : 2'd1;
      step();
      chk($sformatf("switch_b%0d_lane8", b), out_data[8*W +: W],
          64'h1000 + 64'(b) * 64'h100 + ((b < 16) ? 64'd8 : 64'd1));
      chk($sformatf("switch_b%0d_last", b), 64'(out_last), 64'((b == 15) || (b == 31)));
    end
    in_valid = 1'b0;
    step();

    // backpressure: out_ready low for 3 cycles with input held
    flush_pulse();
    cfg_mode = 2'd0;
    out_ready = 1'b1;
    send_held(seq_data(0), 10);
    out_ready = 1'b0;
    send_held(seq_data(1), 10);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_b0", out_data[63:0], 64'h1000);
    in_valid = 1'b1;
    in_data  = seq_data(2);
    step();
    step();
    chk("bp_in_ready_still_low", 64'(in_ready), 64'd0);
    chk("bp_hold_b0_late", out_data[63:0], 64'h1000);
    out_ready = 1'b1;
    step();
    chk("bp_skid_to_out", out_data[63:0], 64'h1100);
    send_held(seq_data(2), 10);
    chk("bp_b2_out", out_data[63:0], 64'h1200);
    send_held(seq_data(3), 10);
    in_valid = 1'b0;
    wait_drain(10);

    // flush at beat 7 of a frame
    flush_pulse();
    cfg_mode = 2'd0;
    for (int b = 0; b < 7; b++) send_held(seq_data(b), 10);
    chk("pre_flush_frame_active", 64'(frame_active), 64'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = seq_data(7);
    #1;
    chk("flush7_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush7_frame_active", 64'(frame_active), 64'd0);
    chk("flush7_out_valid", 64'(out_valid), 64'd0);
    chk_data("flush7_out_data", out_data, '0);
    cfg_mode = 2'd3;
    cfg_rot  = 4'd5;
    send_held(seq_data(8), 10);
    in_valid = 1'b0;
    chk("post_flush_new_frame_rot", out_data[5*W +: W], 64'h1800);
    chk("post_flush_last", 64'(out_last), 64'd0);
    step();

    // randomized traffic against the scoreboard
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_rot   = 4'($urandom_range(0, 15));
      in_data   = rand_data();
      flush     = ($urandom_range(0, 59) == 0);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(10);

    // async reset mid-frame with both registers full
    flush_pulse();
    cfg_mode = 2'd0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_data = seq_data(b);
      step();
    end
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_last", 64'(out_last), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_frame_active", 64'(frame_active), 64'd0);
    chk_data("arst_out_data", out_data, '0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    cfg_mode = 2'd2;
    send_held(seq_data(9), 10);
    in_valid = 1'b0;
    chk("post_rst_stride_lane4", out_data[4*W +: W], 64'h1901);
    wait_drain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
